// File: rtl/ixc_readback_48.sv
// Snapshot a WIDTH-bit design bus on request and stream it out LSB-first as CHUNK-bit beats.
// Optional trailing XOR checksum beat when IXC_READBACK_CKSUM_EN is defined.
module ixc_readback_48 #(
  parameter int WIDTH = 48,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             req_drop
);

  localparam int BEATS = WIDTH / CHUNK;
`ifdef IXC_READBACK_CKSUM_EN
  localparam int FRAME = BEATS + 1;
`else
  localparam int FRAME = BEATS;
`endif
  localparam int KW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_width_check
      $error("ixc_readback_48: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef IXC_READBACK_CKSUM_EN
  function automatic logic [CHUNK-1:0] xor_fold(input logic [WIDTH-1:0] s);
    logic [CHUNK-1:0] acc;
    acc = {CHUNK{1'b0}};
    for (int i = 0; i < BEATS; i++) begin
      acc = acc ^ s[i*CHUNK +: CHUNK];
    end
    return acc;
  endfunction
`endif

  // Beat k of the frame: data chunk k, or the checksum for the trailing beat.
  function automatic logic [CHUNK-1:0] chunk_at(input logic [WIDTH-1:0] s, input logic [KW-1:0] k);
    logic [CHUNK-1:0] c;
    c = {CHUNK{1'b0}};
    for (int i = 0; i < BEATS; i++) begin
      c = (k == KW'(i)) ? s[i*CHUNK +: CHUNK] : c;
    end
`ifdef IXC_READBACK_CKSUM_EN
    c = (k == KW'(BEATS)) ? xor_fold(s) : c;
`endif
    return c;
  endfunction

  state_t           state_r, state_s;
  logic [KW-1:0]    beat_r, beat_s;
  logic [WIDTH-1:0] snap_r, snap_s;
  logic             valid_r, valid_s;
  logic [CHUNK-1:0] data_r, data_s;
  logic             last_r, last_s;
  logic             busy_r, busy_s;
  logic             drop_r, drop_s;
  logic             hs_s;
  logic [KW-1:0]    beat_inc_s;

  assign hs_s       = valid_r & out_ready;
  assign beat_inc_s = beat_r + KW'(1);

  // Next-state and next-output logic; all outputs are registered copies of these.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    snap_s  = snap_r;
    valid_s = valid_r;
    data_s  = data_r;
    last_s  = last_r;
    busy_s  = busy_r;
    drop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = SEND;
          snap_s  = R;
          beat_s  = {KW{1'b0}};
          valid_s = 1'b1;
          busy_s  = 1'b1;
          data_s  = R[CHUNK-1:0];
          last_s  = (K_LAST == {KW{1'b0}});
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // Requests during a frame, including its final handshake cycle, are dropped.
        drop_s = req;
        if (hs_s) begin
          if (beat_r == K_LAST) begin
            state_s = IDLE;
            beat_s  = {KW{1'b0}};
            valid_s = 1'b0;
            busy_s  = 1'b0;
            data_s  = {CHUNK{1'b0}};
            last_s  = 1'b0;
          end else begin
            beat_s  = beat_inc_s;
            data_s  = chunk_at(snap_r, beat_inc_s);
            last_s  = (beat_inc_s == K_LAST);
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        beat_s  = {KW{1'b0}};
        snap_s  = {WIDTH{1'b0}};
        valid_s = 1'b0;
        data_s  = {CHUNK{1'b0}};
        last_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      beat_r  <= {KW{1'b0}};
      snap_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {CHUNK{1'b0}};
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      snap_r  <= snap_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      drop_r  <= drop_s;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_last  = last_r;
  assign busy      = busy_r;
  assign req_drop  = drop_r;

endmodule

// File: tb/tb_ixc_readback_48.sv
// Bench for ixc_readback_48: queue-based frame model, directed scenarios and random traffic.
// Define IXC_READBACK_CKSUM_EN for both RTL and bench to check the checksum beat.
module tb_ixc_readback_48;

  localparam int W  = 48;
  localparam int C  = 8;
  localparam int NB = W / C;
`ifdef IXC_READBACK_CKSUM_EN
  localparam int FB = NB + 1;
`else
  localparam int FB = NB;
`endif
  localparam logic [W-1:0] R0 = 48'h0123_4567_89AB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] R = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [C-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         req_drop;

  int total = 0;
  int bad = 0;

  // Model: the beats still owed by the current frame; the head is what must be on out_data.
  logic [C-1:0] q[$];
  logic         exp_valid, exp_busy, exp_drop, exp_last;
  logic [C-1:0] exp_data;

  ixc_readback_48 #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .R(R),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand48();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic load_frame(input logic [W-1:0] r);
    logic [C-1:0] x;
    x = '0;
    q.delete();
    for (int i = 0; i < NB; i++) begin
      q.push_back(r[i*C +: C]);
      x = x ^ r[i*C +: C];
    end
`ifdef IXC_READBACK_CKSUM_EN
    q.push_back(x);
`endif
  endtask

  task automatic model_clear();
    q.delete();
    exp_valid = 1'b0; exp_busy = 1'b0; exp_drop = 1'b0; exp_last = 1'b0; exp_data = '0;
  endtask

  // Called at a falling edge: drive inputs, advance the model across the next rising edge.
  task automatic tick(input logic rq, input logic rd, input logic [W-1:0] rv);
    logic nd;
    req = rq; out_ready = rd; R = rv;
    nd = rq && exp_busy;
    if (exp_valid && rd) void'(q.pop_front());
    else if (!exp_busy && rq) load_frame(rv);
    @(posedge clk);
    @(negedge clk);
    exp_drop  = nd;
    exp_valid = (q.size() != 0);
    exp_busy  = exp_valid;
    exp_last  = (q.size() == 1);
    exp_data  = exp_valid ? q[0] : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    total++; if ({out_valid, busy, out_last, req_drop} !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b want=0000", {out_valid, busy, out_last, req_drop}); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    rst_n = 1'b1;
    tick(1'b0, 1'b1, rand48());
    total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_idle got=%b want=00", {out_valid, busy}); end
  endtask

  task automatic test_directed();
    logic [C-1:0] seq [7];
    seq = '{8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h22};
    tick(1'b1, 1'b1, R0);
    for (int i = 0; i < FB; i++) begin
      total++; if ({out_valid, busy} !== 2'b11) begin bad++; $display("FAIL dir_valid beat=%0d got=%b want=11", i, {out_valid, busy}); end
      total++; if (out_data !== seq[i]) begin bad++; $display("FAIL dir_data beat=%0d got=%h want=%h", i, out_data, seq[i]); end
      total++; if (out_last !== (i == FB - 1)) begin bad++; $display("FAIL dir_last beat=%0d got=%b want=%b", i, out_last, (i == FB - 1)); end
      tick(1'b0, 1'b1, R0);
    end
    total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL dir_end got=%b want=00", {out_valid, busy}); end
  endtask

  task automatic test_stall();
    logic [W-1:0] r;
    logic         rd;
    int           hs;
    int           cyc;
    for (int f = 0; f < 3; f++) begin
      r = rand48();
      tick(1'b1, 1'b0, r);
      hs = 0; cyc = 0;
      while (hs < FB && cyc < 60) begin
        rd = (f == 0) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
        total++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin bad++; $display("FAIL stall_ctl f=%0d cyc=%0d got=%b want=%b", f, cyc, {out_valid, busy}, {exp_valid, exp_busy}); end
        total++; if (exp_valid && {out_data, out_last} !== {exp_data, exp_last}) begin bad++; $display("FAIL stall_beat f=%0d cyc=%0d got=%h/%b want=%h/%b", f, cyc, out_data, out_last, exp_data, exp_last); end
        if (out_valid && rd) hs++;
        tick(1'b0, rd, rand48());
        cyc++;
      end
      total++; if (hs != FB) begin bad++; $display("FAIL stall_count f=%0d got=%0d want=%0d", f, hs, FB); end
      total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL stall_end f=%0d got=%b want=00", f, {out_valid, busy}); end
    end
  endtask

  task automatic test_req_drop();
    int  drops;
    logic rq;
    drops = 0;
    tick(1'b1, 1'b1, R0);
    for (int n = 0; n < FB; n++) begin
      total++; if (out_data !== exp_data) begin bad++; $display("FAIL drop_data beat=%0d got=%h want=%h", n, out_data, exp_data); end
      rq = (n == 3) || (n == FB - 1);
      tick(rq, 1'b1, rand48());
      total++; if (req_drop !== exp_drop) begin bad++; $display("FAIL drop_pulse beat=%0d got=%b want=%b", n, req_drop, exp_drop); end
      if (req_drop === 1'b1) drops++;
    end
    total++; if (drops != 2) begin bad++; $display("FAIL drop_count got=%0d want=2", drops); end
    tick(1'b0, 1'b1, R0);
    total++; if ({out_valid, busy, req_drop} !== 3'b000) begin bad++; $display("FAIL drop_noframe got=%b want=000", {out_valid, busy, req_drop}); end
  endtask

  task automatic test_capture_isolation();
    tick(1'b1, 1'b1, R0);
    for (int n = 0; n < FB; n++) begin
      total++; if ({out_valid, out_data} !== {1'b1, exp_data}) begin bad++; $display("FAIL iso_beat beat=%0d got=%b/%h want=1/%h", n, out_valid, out_data, exp_data); end
      tick(1'b0, 1'b1, (n == 0) ? 48'h0 : rand48());
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL iso_end got=%b want=0", out_valid); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] rb;
    tick(1'b1, 1'b1, R0);
    tick(1'b0, 1'b1, R0);
    tick(1'b0, 1'b1, R0);
    total++; if (out_data !== 8'h67) begin bad++; $display("FAIL arst_beat2 got=%h want=67", out_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, busy, out_last, req_drop, out_data} !== 12'h000) begin bad++; $display("FAIL arst_clear got=%b/%h want=0000/00", {out_valid, busy, out_last, req_drop}, out_data); end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, R0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_idle got=%b want=0", out_valid); end
    rb = rand48();
    tick(1'b1, 1'b1, rb);
    total++; if ({out_valid, out_data} !== {1'b1, rb[7:0]}) begin bad++; $display("FAIL arst_first got=%b/%h want=1/%h", out_valid, out_data, rb[7:0]); end
    for (int n = 0; n < FB; n++) begin
      total++; if ({out_valid, out_data, out_last} !== {exp_valid, exp_data, exp_last}) begin bad++; $display("FAIL arst_beat beat=%0d got=%b/%h/%b want=%b/%h/%b", n, out_valid, out_data, out_last, exp_valid, exp_data, exp_last); end
      tick(1'b0, 1'b1, rand48());
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_end got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    logic rq, rd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rq = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) != 0);
      tick(rq, rd, rand48());
      total++; if ({out_valid, busy, req_drop} !== {exp_valid, exp_busy, exp_drop}) begin bad++; $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", cyc, {out_valid, busy, req_drop}, {exp_valid, exp_busy, exp_drop}); end
      total++; if (exp_valid && {out_data, out_last} !== {exp_data, exp_last}) begin bad++; $display("FAIL rnd_beat cyc=%0d got=%h/%b want=%h/%b", cyc, out_data, out_last, exp_data, exp_last); end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_req_drop();
    test_capture_isolation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
